// File: rtl/twowire_pkg.sv
// Shared Two-Wire Debug definitions: command codes, host FSM states and
// payload helpers used by the host core.
package twowire_pkg;

  localparam logic [3:0] CMD_DISCONNECT  = 4'h0;
  localparam logic [3:0] CMD_RD_IDCODE   = 4'h1;
  localparam logic [3:0] CMD_RD_STATUS   = 4'h2;
  localparam logic [3:0] CMD_WR_CSR      = 4'h3;
  localparam logic [3:0] CMD_RD_ADDR     = 4'h4;
  localparam logic [3:0] CMD_WR_ADDR     = 4'h5;
  localparam logic [3:0] CMD_RD_DATA     = 4'h7;
  localparam logic [3:0] CMD_RD_DATA_INC = 4'h8;
  localparam logic [3:0] CMD_WR_DATA     = 4'h9;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_START,
    ST_CMD,
    ST_CPAR,
    ST_TURN1,
    ST_PAYLOAD,
    ST_PPAR,
    ST_TURN2,
    ST_GAP
  } tw_state_e;

  function automatic logic cmd_is_write(input logic [3:0] cmd);
    return cmd inside {CMD_WR_CSR, CMD_WR_ADDR, CMD_WR_DATA};
  endfunction

  function automatic logic cmd_is_read(input logic [3:0] cmd);
    return cmd inside {CMD_RD_IDCODE, CMD_RD_STATUS, CMD_RD_ADDR,
                       CMD_RD_DATA, CMD_RD_DATA_INC};
  endfunction

  // Address commands carry 8*(1+asize) bits, everything else a full word.
  function automatic logic [5:0] cmd_payload_len(input logic [3:0] cmd,
                                                 input logic [1:0] asize);
    if (cmd == CMD_RD_ADDR || cmd == CMD_WR_ADDR)
      return {1'b0, asize, 3'b000} + 6'd8;
    return 6'd32;
  endfunction

  function automatic logic [31:0] bswap32(input logic [31:0] v);
    return {v[7:0], v[15:8], v[23:16], v[31:24]};
  endfunction

  // Shift-register contents hold the last len received bits at the bottom;
  // left-align them before swapping so short payloads come back zero-extended.
  function automatic logic [31:0] rd_unswap(input logic [31:0] sh,
                                            input logic [5:0]  len);
    return bswap32(sh << (6'd32 - len));
  endfunction

endpackage

// File: rtl/twowire_host_core_if.sv
// Request/response handshake between the host request queue and the
// Two-Wire host core.
interface twowire_host_core_if;
  logic        req_vld;
  logic        req_rdy;
  logic [3:0]  req_cmd;
  logic [31:0] req_wdata;
  logic        rsp_vld;
  logic [31:0] rsp_rdata;
  logic        rsp_perr;

  modport master (
    output req_vld, req_cmd, req_wdata,
    input  req_rdy, rsp_vld, rsp_rdata, rsp_perr
  );

  modport slave (
    input  req_vld, req_cmd, req_wdata,
    output req_rdy, rsp_vld, rsp_rdata, rsp_perr
  );
endinterface

// File: rtl/twowire_host_bitclk.sv
// DCK generator: splits each bit period into a drive half (DCK low) and a
// sample half (DCK high), advancing only on tick while a frame is running.
module twowire_host_bitclk (
  input  logic clk,
  input  logic drst_n,
  input  logic tick,
  input  logic run,
  output logic dck_o,
  output logic drive_strobe,
  output logic sample_strobe
);

  logic phase;

  assign drive_strobe  = tick & run & ~phase;
  assign sample_strobe = tick & run &  phase;

  always_ff @(posedge clk or negedge drst_n) begin
    if (!drst_n) begin
      phase <= 1'b0;
      dck_o <= 1'b0;
    end else if (!run) begin
      phase <= 1'b0;
      dck_o <= 1'b0;
    end else if (tick) begin
      phase <= ~phase;
      dck_o <= phase;
    end
  end

endmodule

// File: rtl/twowire_host_core.sv
// Two-Wire Debug host initiator: serialises one command per request onto
// DCK/DIO and returns one response per request.
module twowire_host_core
  import twowire_pkg::*;
#(
  parameter int unsigned ASIZE    = 0,
  parameter int unsigned GAP_BITS = 2
) (
  input  logic                clk,
  input  logic                drst_n,
  input  logic                tick,
  twowire_host_core_if.slave  hif,
  output logic                dck_o,
  output logic                dio_o,
  output logic                dio_oe,
  input  logic                dio_i
);

  localparam logic [1:0] ASZ      = ASIZE[1:0];
  localparam logic [5:0] GAP_LAST = 6'(GAP_BITS - 1);

  tw_state_e   state;
  logic [5:0]  cnt;
  logic [3:0]  cmd_q;
  logic [31:0] sh;
  logic        par;
  logic        perr_q;
  logic        req_rdy_q;
  logic        rsp_vld_q;
  logic [31:0] rsp_rdata_q;
  logic        rsp_perr_q;

  logic        run;
  logic        drive_stb;
  logic        samp_stb;
  logic        is_wr;
  logic        is_rd;
  logic [5:0]  plen;
  logic [31:0] rsp_data_nxt;
  logic        rsp_perr_nxt;

  assign run          = (state != ST_IDLE);
  assign is_wr        = cmd_is_write(cmd_q);
  assign is_rd        = cmd_is_read(cmd_q);
  assign plen         = cmd_payload_len(cmd_q, ASZ);
  assign rsp_data_nxt = is_rd ? rd_unswap(sh, plen) : '0;
  assign rsp_perr_nxt = is_rd & perr_q;

  assign hif.req_rdy   = req_rdy_q;
  assign hif.rsp_vld   = rsp_vld_q;
  assign hif.rsp_rdata = rsp_rdata_q;
  assign hif.rsp_perr  = rsp_perr_q;

  twowire_host_bitclk u_bitclk (
    .clk           (clk),
    .drst_n        (drst_n),
    .tick          (tick),
    .run           (run),
    .dck_o         (dck_o),
    .drive_strobe  (drive_stb),
    .sample_strobe (samp_stb)
  );

  // State names the bit currently on the wire: it is driven on the drive
  // strobe and the FSM moves on at the sample strobe that closes the bit.
  always_ff @(posedge clk or negedge drst_n) begin
    if (!drst_n) begin
      state       <= ST_IDLE;
      cnt         <= '0;
      cmd_q       <= '0;
      sh          <= '0;
      par         <= 1'b0;
      perr_q      <= 1'b0;
      dio_o       <= 1'b1;
      dio_oe      <= 1'b1;
      req_rdy_q   <= 1'b1;
      rsp_vld_q   <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_perr_q  <= 1'b0;
    end else begin
      rsp_vld_q <= 1'b0;
      if (state == ST_IDLE) begin
        if (hif.req_vld && req_rdy_q) begin
          cmd_q     <= hif.req_cmd;
          sh        <= bswap32(hif.req_wdata);
          perr_q    <= 1'b0;
          req_rdy_q <= 1'b0;
          state     <= ST_START;
        end
      end else if (drive_stb) begin
        case (state)
          ST_START: begin
            dio_o  <= 1'b0;
            dio_oe <= 1'b1;
          end
          ST_CMD:   dio_o  <= cmd_q[cnt[1:0]];
          ST_CPAR:  dio_o  <= ^cmd_q;
          ST_TURN1: dio_oe <= 1'b0;
          ST_PAYLOAD: begin
            if (is_wr) begin
              dio_o <= sh[31];
              par   <= par ^ sh[31];
              sh    <= {sh[30:0], 1'b0};
            end
          end
          ST_PPAR: begin
            if (is_wr) dio_o <= par;
          end
          ST_TURN2, ST_GAP: begin
            dio_o  <= 1'b1;
            dio_oe <= 1'b1;
          end
          default: ;
        endcase
      end else if (samp_stb) begin
        case (state)
          ST_START: begin
            state <= ST_CMD;
            cnt   <= 6'd3;
          end
          ST_CMD: begin
            if (cnt == '0) state <= ST_CPAR;
            else           cnt   <= cnt - 6'd1;
          end
          ST_CPAR: begin
            par <= 1'b0;
            if (is_wr) begin
              state <= ST_PAYLOAD;
              cnt   <= plen - 6'd1;
            end else if (is_rd) begin
              state <= ST_TURN1;
            end else begin
              state       <= ST_GAP;
              cnt         <= GAP_LAST;
              rsp_vld_q   <= 1'b1;
              rsp_rdata_q <= rsp_data_nxt;
              rsp_perr_q  <= rsp_perr_nxt;
            end
          end
          ST_TURN1: begin
            state <= ST_PAYLOAD;
            cnt   <= plen - 6'd1;
          end
          ST_PAYLOAD: begin
            if (is_rd) begin
              sh  <= {sh[30:0], dio_i};
              par <= par ^ dio_i;
            end
            if (cnt == '0) state <= ST_PPAR;
            else           cnt   <= cnt - 6'd1;
          end
          ST_PPAR: begin
            if (is_rd) begin
              perr_q <= par ^ dio_i;
              state  <= ST_TURN2;
            end else begin
              state       <= ST_GAP;
              cnt         <= GAP_LAST;
              rsp_vld_q   <= 1'b1;
              rsp_rdata_q <= rsp_data_nxt;
              rsp_perr_q  <= rsp_perr_nxt;
            end
          end
          ST_TURN2: begin
            state       <= ST_GAP;
            cnt         <= GAP_LAST;
            rsp_vld_q   <= 1'b1;
            rsp_rdata_q <= rsp_data_nxt;
            rsp_perr_q  <= rsp_perr_nxt;
          end
          ST_GAP: begin
            if (cnt == '0) begin
              state     <= ST_IDLE;
              req_rdy_q <= 1'b1;
            end else begin
              cnt <= cnt - 6'd1;
            end
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule
